// File: rtl/dec_unbinder_pack_40_pkg.sv
// Shared constants for the decode-side binder packs: hypervector width, the SHIFTS table
// and the per-pack channel typedefs.
package dec_unbinder_pack_40_pkg;

    localparam int unsigned HV_DIM          = 64;
    localparam int unsigned NUM_SHIFTS      = 512;
    localparam int unsigned NUM_CH_PER_PACK = 10;

    typedef logic [$clog2(NUM_CH_PER_PACK)-1:0] ch_idx_t;
    typedef logic [HV_DIM-1:0]                  hv_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } dec_state_e;

    // SHIFTS[idx]; entries may exceed HV_DIM and are reduced mod HV_DIM by the user.
    function automatic int unsigned shift_of(input int unsigned idx);
        int unsigned s;
        case (idx)
            400:     s = 5;
            401:     s = 0;
            402:     s = 63;
            403:     s = 64;
            404:     s = 100;
            405:     s = 1;
            406:     s = 17;
            407:     s = 128;
            408:     s = 33;
            409:     s = 200;
            default: s = (idx * 7919 + 13) % 1021;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dec_unbinder_pack_40_hv_unrotate.sv
// Fixed rotation that undoes one binder channel: out_hv[j] = in_hv[(j + SHIFT) mod HV_DIM].
// Pure wiring; SHIFT is reduced mod HV_DIM so SHIFT = 0 or a multiple of HV_DIM passes through.
module hv_unrotate
    import dec_unbinder_pack_40_pkg::*;
#(
    parameter int unsigned SHIFT = 0
) (
    input  logic [HV_DIM-1:0] in_hv,
    output logic [HV_DIM-1:0] out_hv
);

    localparam int unsigned S = SHIFT % HV_DIM;

    for (genvar j = 0; j < HV_DIM; j++) begin : g_bit
        localparam int unsigned SRC = (j + S) % HV_DIM;
        assign out_hv[j] = in_hv[SRC];
    end

endmodule

// File: rtl/dec_unbinder_pack_40.sv
// Streaming unbinder for channels SHIFTS[BASE_IDX .. BASE_IDX+NUM_CH-1]: each accepted beat is
// rotated back by its channel's shift and presented on a registered valid/ready output.
module dec_unbinder_pack_40
    import dec_unbinder_pack_40_pkg::*;
#(
    parameter int unsigned NUM_CH   = NUM_CH_PER_PACK,
    parameter int unsigned BASE_IDX = 400
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_decoding,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [HV_DIM-1:0]         in_hv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [HV_DIM-1:0]         out_hv,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err_start
);

    localparam int unsigned CW = $clog2(NUM_CH);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST_CH = cnt_t'(NUM_CH - 1);

    dec_state_e state_q, state_d;

    cnt_t              cnt_q, cnt_d;
    cnt_t              ch_q, ch_d;
    logic [HV_DIM-1:0] hv_q, hv_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [HV_DIM-1:0] rot [NUM_CH];
    logic [HV_DIM-1:0] rot_sel;
    logic              in_hs;
    logic              out_hs;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_rot
        hv_unrotate #(
            .SHIFT(shift_of(BASE_IDX + i))
        ) u_unrotate (
            .in_hv (in_hv),
            .out_hv(rot[i])
        );
    end

    always_comb begin
        rot_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_q == cnt_t'(i)) begin
                rot_sel = rot[i];
            end
        end
    end

    assign in_hs  = in_valid && in_ready;
    assign out_hs = valid_q && out_ready;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. DRAIN is held through the frame_done cycle so a start there is an error.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_decoding) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (in_hs && (cnt_q == LAST_CH)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (done_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StRun:   in_ready = !valid_q || out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        hv_d    = hv_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = (state_q == StDrain) && out_hs && last_q;

        if (out_hs) begin
            valid_d = 1'b0;
        end
        if (in_hs) begin
            valid_d = 1'b1;
            hv_d    = rot_sel;
            ch_d    = cnt_q;
            last_d  = (cnt_q == LAST_CH);
            if (cnt_q != LAST_CH) begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
        if (start_decoding) begin
            if (state_q == StIdle) begin
                cnt_d  = '0;
                busy_d = 1'b1;
                err_d  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (done_d) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            ch_q    <= '0;
            hv_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            hv_q    <= hv_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_hv     = hv_q;
    assign out_ch     = ch_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign err_start  = err_q;

endmodule

// File: tb/tb_dec_unbinder_pack_40.sv
// Randomized bench for dec_unbinder_pack_40 against a queue-based frame model.
module tb_dec_unbinder_pack_40;

    localparam int unsigned D = 64;

    logic         clk;
    logic         rst;
    logic         start_decoding;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_hv;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_hv;
    logic [3:0]   out_ch;
    logic         out_last;
    logic         busy;
    logic         frame_done;
    logic         err_start;

    dec_unbinder_pack_40 dut (
        .clk           (clk),
        .rst           (rst),
        .start_decoding(start_decoding),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_hv         (in_hv),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_hv        (out_hv),
        .out_ch        (out_ch),
        .out_last      (out_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_start     (err_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SHIFTS[400..409]
    int unsigned shifts_tb [10] = '{5, 0, 63, 64, 100, 1, 17, 128, 33, 200};

    typedef struct {
        logic [D-1:0] hv;
        int           ch;
        bit           last;
    } beat_t;

    beat_t        q[$];
    beat_t        b;
    logic [D-1:0] lv_cur [10];
    bit           m_busy, m_tail, m_err, nxt_tail, cur_busy;
    bit           exp_ov, exp_ir, o_hs, i_hs;
    int           m_acc, m_outs, frames_done, stall3;
    bit           rand_out, bp_armed;
    int           bp_hold;
    int           n_checks, n_fail;

    task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder binder: bound bit j = level bit (j - s) mod D.
    function automatic logic [D-1:0] bind_hv(input logic [D-1:0] lv, input int unsigned s);
        logic [D-1:0] r;
        int unsigned  sm;
        sm = s % D;
        for (int j = 0; j < D; j++) r[j] = lv[(j + D - sm) % D];
        return r;
    endfunction

    // Frame model and per-cycle compare.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_busy = 0;
            m_tail = 0;
            m_err  = 0;
            m_acc  = 0;
        end else begin
            exp_ov = (q.size() != 0);
            exp_ir = m_busy && (m_acc < 10) && (!exp_ov || out_ready);
            check("in_ready", in_ready, exp_ir);
            check("out_valid", out_valid, exp_ov);
            check("busy", busy, m_busy);
            check("err_start", err_start, m_err);
            check("frame_done", frame_done, m_tail);
            if (exp_ov) begin
                check($sformatf("out_hv_ch%0d", q[0].ch), out_hv, q[0].hv);
                check("out_ch", out_ch, q[0].ch);
                check("out_last", out_last, q[0].last);
                if (!out_ready && q[0].ch == 3) stall3++;
            end
            cur_busy = m_busy;
            o_hs     = exp_ov && out_ready;
            i_hs     = in_valid && exp_ir;
            nxt_tail = 0;
            if (o_hs) begin
                b = q.pop_front();
                m_outs++;
                if (b.last) begin
                    nxt_tail = 1;
                    m_busy   = 0;
                end
            end
            if (i_hs) begin
                b.hv   = lv_cur[m_acc];
                b.ch   = m_acc;
                b.last = (m_acc == 9);
                q.push_back(b);
                m_acc++;
            end
            if (m_tail) frames_done++;
            if (start_decoding) begin
                if (!cur_busy && !m_tail) begin
                    m_busy = 1;
                    m_acc  = 0;
                    m_err  = 0;
                    m_outs = 0;
                end else begin
                    m_err = 1;
                end
            end
            m_tail = nxt_tail;
        end
    end

    // Output-side backpressure driver.
    initial begin
        out_ready = 1'b1;
        bp_hold   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_armed && q.size() != 0 && q[0].ch == 3) begin
                bp_armed = 0;
                bp_hold  = 5;
            end
            if (bp_hold > 0) begin
                out_ready = 1'b0;
                bp_hold--;
            end else begin
                out_ready = rand_out ? ($urandom % 4 != 0) : 1'b1;
            end
        end
    end

    task automatic run_frame(input bit rand_in, input int err_at, input int rst_at,
                             input int onehot);
        int  start_frames;
        int  idx;
        bit  err_done;
        bit  done;
        for (int k = 0; k < 10; k++) lv_cur[k] = {$urandom, $urandom};
        if (onehot == 1) lv_cur[0] = 64'h0800_0000_0000_0000;
        if (onehot == 2) lv_cur[0] = 64'h0400_0000_0000_0000;
        start_frames = frames_done;
        err_done     = 0;
        done         = 0;
        @(posedge clk);
        #1;
        start_decoding = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            start_decoding = 1'b0;
            if (frames_done != start_frames) begin
                done = 1;
                break;
            end
            if (rst_at >= 0 && m_acc == rst_at + 1) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                #1;
                check("rst_ctrl_zero",
                      {out_valid, in_ready, busy, frame_done, err_start, out_last, out_ch}, '0);
                check("rst_hv_zero", out_hv, '0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (err_at >= 0 && !err_done && m_acc == err_at) begin
                start_decoding = 1'b1;
                err_done       = 1;
            end
            in_valid = (m_busy && m_acc < 10) ? (rand_in ? ($urandom % 3 != 0) : 1'b1) : 1'b0;
            idx      = (m_acc < 10) ? m_acc : 9;
            in_hv    = bind_hv(lv_cur[idx], shifts_tb[idx]);
            if (idx == 0 && onehot == 1) in_hv = 64'h0000_0000_0000_0001;
            if (idx == 0 && onehot == 2) in_hv = 64'h8000_0000_0000_0000;
        end
        in_valid = 1'b0;
        if (!done) check("frame_timeout", 0, 1);
    endtask

    initial begin
        rst            = 1'b1;
        start_decoding = 1'b0;
        in_valid       = 1'b0;
        in_hv          = '0;
        rand_out       = 0;
        bp_armed       = 0;
        n_checks       = 0;
        n_fail         = 0;
        frames_done    = 0;
        m_outs         = 0;
        stall3         = 0;

        // Hand-computed pins of the binder model.
        check("pin_bind_s5_b59", bind_hv(64'h0800_0000_0000_0000, 5), 64'h1);
        check("pin_bind_s5_b58", bind_hv(64'h0400_0000_0000_0000, 5), 64'h8000_0000_0000_0000);
        check("pin_bind_s1", bind_hv(64'h1, 1), 64'h2);
        check("pin_bind_s64", bind_hv(64'hdead_beef_0123_4567, 64), 64'hdead_beef_0123_4567);
        check("pin_bind_s100", bind_hv(64'h1, 100), 64'h0000_0010_0000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl",
              {out_valid, in_ready, busy, frame_done, err_start, out_last, out_ch}, '0);
        check("reset_hv", out_hv, '0);
        rst = 1'b0;

        run_frame(0, -1, -1, 0);
        check("roundtrip_outs", m_outs, 10);
        run_frame(0, -1, -1, 1);
        run_frame(0, -1, -1, 2);

        bp_armed = 1;
        stall3   = 0;
        run_frame(0, -1, -1, 0);
        check("bp_stall_cycles", stall3, 5);
        check("bp_outs", m_outs, 10);

        run_frame(0, 4, -1, 0);
        check("err_sticky", err_start, 1);
        check("err_frame_outs", m_outs, 10);
        run_frame(0, -1, -1, 0);
        check("err_cleared", err_start, 0);

        run_frame(0, -1, 6, 0);
        run_frame(0, -1, -1, 0);
        check("post_rst_outs", m_outs, 10);

        in_valid = 1'b1;
        in_hv    = '1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        rand_out = 1;
        for (int f = 0; f < 20; f++) begin
            run_frame(1, -1, -1, 0);
            check("rand_outs", m_outs, 10);
        end
        rand_out = 0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
